// File: rtl/am_mod.sv
// AM generator: phase-continuous carrier from a 2 MHz NCO, amplitude-modulated by a
// sine envelope whose depth/frequency are updated only at modulating-phase wraps.
//
// state | meaning
// IDLE  | generation disabled, no pending config
// RUN   | generation enabled, no pending config
// PEND  | config latched, waiting for pm wrap (or immediate apply when disabled)
module am_mod #(
    parameter logic [31:0] CARRIER_FCW  = 32'h3E80_0000,
    parameter logic [7:0]  MA_DEFAULT   = 8'd50,
    parameter logic [7:0]  FREQ_DEFAULT = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_ma,
    input  logic [7:0] cfg_freq,
    output logic       cfg_err,
    output logic [9:0] dac_data,
    output logic       out_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} state_t;

    localparam longint PI_FX = 64'sd3373259426;   // pi * 2^30

    // Quarter-wave table entry: round(511*sin(pi*i/512)), Taylor series in 2^30 fixed point.
    function automatic logic [8:0] qsin(input int i);
        longint x, x2, term, acc;
        x    = (PI_FX * longint'(i)) >>> 9;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return 9'((acc * 511 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [8:0] qtab [0:256];
    for (genvar gi = 0; gi <= 256; gi++) begin : g_qtab
        localparam logic [8:0] QV = qsin(gi);
        assign qtab[gi] = QV;
    end

    state_t state, state_nxt;
    logic [31:0] pc, pm, pm_inc;
    logic [32:0] pm_sum;
    logic [7:0]  ma_r, freq_r, pend_ma, pend_freq;
    logic        cfg_take, cfg_bad, upd;

    assign pm_inc   = {5'd0, freq_r, 19'd0};
    assign pm_sum   = {1'b0, pm} + {1'b0, pm_inc};
    assign cfg_bad  = (cfg_freq == 8'd0) || (cfg_freq > 8'd5);
    assign cfg_take = cfg_valid & cfg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (cfg_take && !cfg_bad) state_nxt = ST_PEND;
                else                      state_nxt = en ? ST_RUN : ST_IDLE;
            end
            ST_PEND: begin
                if (!en)            state_nxt = ST_IDLE;
                else if (pm_sum[32]) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state != ST_PEND);
        upd       = (state == ST_PEND) && (!en || pm_sum[32]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma_r      <= MA_DEFAULT;
            freq_r    <= FREQ_DEFAULT;
            pend_ma   <= 8'd0;
            pend_freq <= 8'd0;
            cfg_err   <= 1'b0;
            pc        <= 32'd0;
            pm        <= 32'd0;
        end else begin
            cfg_err <= cfg_take & cfg_bad;
            if (cfg_take && !cfg_bad) begin
                pend_ma   <= (cfg_ma > 8'd100) ? 8'd100 : cfg_ma;
                pend_freq <= cfg_freq;
            end
            if (upd) begin
                ma_r   <= pend_ma;
                freq_r <= pend_freq;
            end
            if (en) begin
                pc <= pc + CARRIER_FCW;
                pm <= pm_sum[31:0];
            end
        end
    end

    // Sample pipeline; depth travels with the phase so each sample is self-consistent.
    logic              v1, v2, v3, v4;
    logic [9:0]        kc1, km1;
    logic [7:0]        ma1, ma2;
    logic signed [9:0] c2, m2, c3, s4;
    logic [16:0]       env3;
    logic [8:0]        c_idx, m_idx;
    logic signed [9:0] c_mag, m_mag, c_lut, m_lut;
    logic signed [17:0] prod_m, env_sum;
    logic signed [27:0] prod_c;
    logic              unused_bits;

    always_comb begin
        c_idx  = kc1[8] ? 9'd256 - {1'b0, kc1[7:0]} : {1'b0, kc1[7:0]};
        m_idx  = km1[8] ? 9'd256 - {1'b0, km1[7:0]} : {1'b0, km1[7:0]};
        c_mag  = $signed({1'b0, qtab[c_idx]});
        m_mag  = $signed({1'b0, qtab[m_idx]});
        c_lut  = kc1[9] ? -c_mag : c_mag;
        m_lut  = km1[9] ? -m_mag : m_mag;
        prod_m  = $signed({{8{m2[9]}}, m2}) * $signed({10'd0, ma2});
        env_sum = prod_m + 18'sd51200;
        prod_c  = $signed({{18{c3[9]}}, c3}) * $signed({11'd0, env3});
    end

    assign unused_bits = ^{env_sum[17], prod_c[27], prod_c[16:0]};

    always_ff @(posedge clk) begin
        kc1  <= pc[31:22];
        km1  <= pm[31:22];
        ma1  <= ma_r;
        c2   <= c_lut;
        m2   <= m_lut;
        ma2  <= ma1;
        c3   <= c2;
        env3 <= env_sum[16:0];
        s4   <= prod_c[26:17];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            dac_data  <= 10'd512;
        end else begin
            v1        <= en;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            dac_data  <= v4 ? {~s4[9], s4[8:0]} : 10'd512;
        end
    end

endmodule

// File: tb/tb_am_mod.sv
// Bench for am_mod: cycle-level reference model compared every clock, a table of
// configuration offers, and directed sequences for wrap races, en gaps and resets.
module tb_am_mod;

    localparam logic [31:0] FCW = 32'h3E80_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_ma = 8'd0;
    logic [7:0] cfg_freq = 8'd0;
    logic       cfg_ready, cfg_err, out_valid;
    logic [9:0] dac_data;

    always #61 clk = ~clk;

    am_mod dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ma(cfg_ma), .cfg_freq(cfg_freq), .cfg_err(cfg_err),
        .dac_data(dac_data), .out_valid(out_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_pm;
    int m_ma, m_freq, m_pma, m_pfreq, m_st;   // m_st: 0 idle, 1 run, 2 pend
    int m_err;
    int q_v [1:5];
    int q_d [1:5];
    int obs_min, obs_max, obs_gap;

    function automatic int isin(int k);
        real r;
        r = 511.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    function automatic int model_dac(logic [31:0] pc, logic [31:0] pm, int ma);
        longint c, m, env, prod;
        c    = isin(int'(pc[31:22]));
        m    = isin(int'(pm[31:22]));
        env  = 51200 + m * ma;
        prod = c * env;
        return int'(prod >>> 17) + 512;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pm = 0; m_ma = 50; m_freq = 1; m_pma = 0; m_pfreq = 0;
        m_st = 0; m_err = 0;
        for (int i = 1; i <= 5; i++) begin
            q_v[i] = 0;
            q_d[i] = 512;
        end
    endtask

    function automatic bit wrap_next();
        return (longint'(m_pm) + longint'(m_freq) * 524288) >= 64'sd4294967296;
    endfunction

    task automatic model_edge();
        longint sum;
        bit wrap, take, bad;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 5; i > 1; i--) begin
            q_v[i] = q_v[i-1];
            q_d[i] = q_d[i-1];
        end
        q_v[1] = en ? 1 : 0;
        q_d[1] = en ? model_dac(m_pc, m_pm, m_ma) : 512;
        sum  = longint'(m_pm) + longint'(m_freq) * 524288;
        wrap = en && (sum >= 64'sd4294967296);
        take = cfg_valid && (m_st != 2);
        bad  = (cfg_freq < 8'd1) || (cfg_freq > 8'd5);
        m_err = (take && bad) ? 1 : 0;
        if (m_st == 2) begin
            if (!en || wrap) begin
                m_ma = m_pma; m_freq = m_pfreq; m_st = en ? 1 : 0;
            end
        end else if (take && !bad) begin
            m_pma = (cfg_ma > 8'd100) ? 100 : int'(cfg_ma);
            m_pfreq = int'(cfg_freq);
            m_st = 2;
        end else begin
            m_st = en ? 1 : 0;
        end
        if (en) begin
            m_pc = m_pc + FCW;
            m_pm = sum[31:0];
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic win_reset();
        obs_min = 1023; obs_max = 0; obs_gap = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", int'(out_valid), q_v[5]);
        check("dac_data", int'(dac_data), q_d[5]);
        check("cfg_ready", int'(cfg_ready), (m_st != 2) ? 1 : 0);
        check("cfg_err", int'(cfg_err), m_err);
        if (out_valid) begin
            if (int'(dac_data) < obs_min) obs_min = int'(dac_data);
            if (int'(dac_data) > obs_max) obs_max = int'(dac_data);
        end else begin
            obs_gap++;
        end
    endtask

    task automatic wait_applied(string name, int limit, output int waited);
        waited = 0;
        while (m_st == 2 && waited < limit) begin
            tick();
            waited++;
        end
        if (m_st == 2) begin
            errors++;
            $display("FAIL %s: pending config not applied within %0d cycles", name, limit);
        end
    endtask

    typedef struct {
        logic [7:0] ma;
        logic [7:0] freq;
        int         exp_err;
        int         exp_ready;
        int         run;
        bit         probe;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int w;
        vecs[0] = '{ma: 8'd30,  freq: 8'd6,   exp_err: 1, exp_ready: 1, run: 20,    probe: 1'b0};
        vecs[1] = '{ma: 8'd40,  freq: 8'd0,   exp_err: 1, exp_ready: 1, run: 10,    probe: 1'b0};
        vecs[2] = '{ma: 8'd10,  freq: 8'd255, exp_err: 1, exp_ready: 1, run: 10,    probe: 1'b0};
        vecs[3] = '{ma: 8'd0,   freq: 8'd5,   exp_err: 0, exp_ready: 0, run: 400,   probe: 1'b0};
        vecs[4] = '{ma: 8'd200, freq: 8'd2,   exp_err: 0, exp_ready: 0, run: 50,    probe: 1'b0};
        vecs[5] = '{ma: 8'd80,  freq: 8'd3,   exp_err: 0, exp_ready: 0, run: 50,    probe: 1'b1};
        vecs[6] = '{ma: 8'd100, freq: 8'd1,   exp_err: 0, exp_ready: 0, run: 16384, probe: 1'b0};
        model_reset();
        win_reset();

        repeat (3) tick();
        check("rst dac_data", int'(dac_data), 512);
        check("rst out_valid", int'(out_valid), 0);
        check("rst cfg_ready", int'(cfg_ready), 1);
        check("rst cfg_err", int'(cfg_err), 0);

        rst_n = 1'b1;
        en = 1'b1;
        repeat (4) tick();
        check("start ov4", int'(out_valid), 0);
        tick();
        check("start ov5", int'(out_valid), 1);
        check("start dac", int'(dac_data), 512);
        repeat (20) tick();

        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_ma = vecs[i].ma;
            cfg_freq = vecs[i].freq;
            tick();
            cfg_valid = 1'b0;
            check("vec cfg_err", int'(cfg_err), vecs[i].exp_err);
            check("vec cfg_ready", int'(cfg_ready), vecs[i].exp_ready);
            if (vecs[i].probe) begin
                cfg_valid = 1'b1;
                cfg_ma = 8'd10;
                cfg_freq = 8'd2;
                repeat (5) tick();
                cfg_valid = 1'b0;
            end
            wait_applied("vec apply", 9000, w);
            win_reset();
            repeat (vecs[i].run) tick();
            if (i == 3) begin
                check("ma0 max", (obs_max <= 712) ? 1 : 0, 1);
                check("ma0 min", (obs_min >= 312) ? 1 : 0, 1);
            end
            if (i == 6) begin
                check("ma100 max", (obs_max <= 911) ? 1 : 0, 1);
                check("ma100 min", (obs_min >= 113) ? 1 : 0, 1);
                check("ma100 gaps", obs_gap, 0);
            end
        end

        // Offer landing on the same edge as a pm wrap must wait a full period.
        cfg_valid = 1'b1; cfg_ma = 8'd60; cfg_freq = 8'd5;
        tick();
        cfg_valid = 1'b0;
        wait_applied("pre-race apply", 9000, w);
        w = 0;
        while (!wrap_next() && w < 2000) begin
            tick();
            w++;
        end
        check("race wrap found", wrap_next() ? 1 : 0, 1);
        cfg_valid = 1'b1; cfg_ma = 8'd30; cfg_freq = 8'd4;
        tick();
        cfg_valid = 1'b0;
        check("race ready0", int'(cfg_ready), 0);
        tick();
        check("race ready1", int'(cfg_ready), 0);
        wait_applied("race apply", 2000, w);
        check("race full wait", (w > 1600) ? 1 : 0, 1);
        repeat (30) tick();

        // en gap: output drains after 5 cycles, phases resume from held values.
        en = 1'b0;
        repeat (4) tick();
        check("drop ov4", int'(out_valid), 1);
        tick();
        check("drop ov5", int'(out_valid), 0);
        check("drop dac", int'(dac_data), 512);
        cfg_valid = 1'b1; cfg_ma = 8'd20; cfg_freq = 8'd2;
        tick();
        cfg_valid = 1'b0;
        check("idle pend ready", int'(cfg_ready), 0);
        tick();
        check("idle apply ready", int'(cfg_ready), 1);
        repeat (93) tick();
        en = 1'b1;
        repeat (4) tick();
        check("resume ov4", int'(out_valid), 0);
        tick();
        check("resume ov5", int'(out_valid), 1);
        repeat (40) tick();

        // Reset while a config is pending and samples are in flight.
        cfg_valid = 1'b1; cfg_ma = 8'd90; cfg_freq = 8'd4;
        tick();
        cfg_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check("mid rst dac", int'(dac_data), 512);
        check("mid rst ov", int'(out_valid), 0);
        check("mid rst ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        repeat (4) tick();
        check("post rst ov4", int'(out_valid), 0);
        tick();
        check("post rst ov5", int'(out_valid), 1);
        check("post rst dac", int'(dac_data), 512);
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
